// File: rtl/fft_seq_counter.sv
// Two-level FFT sequencer: sample index 0..2^L-1 nested inside stage 0..L-1.
// Optional bit-reversed index output is enabled by defining FFT_CNT_BITREV_EN.
module fft_seq_counter #(
    parameter int W  = 12,
    parameter int SW = 4
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          start,
    input  logic          clr,
    input  logic          ce,
    input  logic [SW-1:0] log2_len,
    output logic [W-1:0]  o_idx,
    output logic [SW-1:0] o_stage,
    output logic [W-1:0]  o_rev,
    output logic          o_last_idx,
    output logic          o_last_stage,
    output logic          busy,
    output logic          o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] len;
    logic [SW-1:0] len_in;
    logic [W:0]    mask;
    logic          idx_end;
    logic          stage_end;

    // Mask is one bit wider than the index so that L = W cannot overflow.
    assign len_in    = (log2_len > SW'(W)) ? SW'(W) : log2_len;
    assign mask      = ((W+1)'(1) << len) - (W+1)'(1);
    assign idx_end   = ({1'b0, o_idx} == mask);
    assign stage_end = (o_stage == len - SW'(1));

    assign o_last_idx   = busy && idx_end;
    assign o_last_stage = busy && stage_end;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            o_idx   <= '0;
            o_stage <= '0;
            len     <= '0;
            busy    <= 1'b0;
            o_done  <= 1'b0;
        end else if (clr) begin
            state   <= IDLE;
            o_idx   <= '0;
            o_stage <= '0;
            len     <= '0;
            busy    <= 1'b0;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && (log2_len != '0)) begin
                        state   <= RUN;
                        len     <= len_in;
                        o_idx   <= '0;
                        o_stage <= '0;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    if (ce) begin
                        if (!idx_end) begin
                            o_idx <= o_idx + W'(1);
                        end else if (!stage_end) begin
                            o_idx   <= '0;
                            o_stage <= o_stage + SW'(1);
                        end else begin
                            o_idx   <= '0;
                            o_stage <= '0;
                            state   <= DONE;
                            busy    <= 1'b0;
                            o_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FFT_CNT_BITREV_EN
    // Reverse only the low L bits; the mux over L keeps every index constant.
    always_comb begin
        o_rev = '0;
        if (busy) begin
            for (int l = 1; l <= W; l++) begin
                if (len == SW'(l)) begin
                    for (int i = 0; i < l; i++) begin
                        o_rev[i] = o_idx[l-1-i];
                    end
                end
            end
        end
    end
`else
    assign o_rev = o_idx;
`endif

endmodule

// File: tb/tb_fft_seq_counter.sv
// Self-checking bench for fft_seq_counter.
// Scoreboard model plus directed milestone checks.
module tb_fft_seq_counter;

  localparam int W  = 12;
  localparam int SW = 4;

  logic          clk;
  logic          nrst;
  logic          start;
  logic          clr;
  logic          ce;
  logic [SW-1:0] log2_len;
  logic [W-1:0]  o_idx;
  logic [SW-1:0] o_stage;
  logic [W-1:0]  o_rev;
  logic          o_last_idx;
  logic          o_last_stage;
  logic          busy;
  logic          o_done;

  fft_seq_counter #(.W(W), .SW(SW)) dut (
    .clk(clk),
    .nrst(nrst),
    .start(start),
    .clr(clr),
    .ce(ce),
    .log2_len(log2_len),
    .o_idx(o_idx),
    .o_stage(o_stage),
    .o_rev(o_rev),
    .o_last_idx(o_last_idx),
    .o_last_stage(o_last_stage),
    .busy(busy),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int stage;
    int rev;
    bit busy;
    bit done;
    bit li;
    bit ls;
  } exp_t;

  exp_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  int m_st  = 0;
  int m_idx = 0;
  int m_stg = 0;
  int m_len = 0;

  task automatic note(input bit ok,
                      input string tag);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  function automatic int rev_of(int v, int l);
    int r = 0;
    for (int i = 0; i < l; i++)
      if (v[i]) r |= (1 << (l - 1 - i));
    return r;
  endfunction

  function automatic void model(bit s, bit c, bit e,
                                int l, bit r);
    int top;
    if (!r || c) begin
      m_st = 0; m_idx = 0; m_stg = 0; m_len = 0;
      return;
    end
    top = (1 << m_len) - 1;
    case (m_st)
      0: if (s && l != 0) begin
        m_len = (l > W) ? W : l;
        m_st = 1; m_idx = 0; m_stg = 0;
      end
      1: if (e) begin
        if (m_idx < top) m_idx++;
        else if (m_stg < m_len - 1) begin
          m_idx = 0; m_stg++;
        end else begin
          m_idx = 0; m_stg = 0; m_st = 2;
        end
      end
      default: m_st = 0;
    endcase
  endfunction

  function automatic exp_t model_out();
    exp_t x;
    x.idx   = m_idx;
    x.stage = m_stg;
    x.busy  = (m_st == 1);
    x.done  = (m_st == 2);
    x.li    = x.busy && (m_idx == (1 << m_len) - 1);
    x.ls    = x.busy && (m_stg == m_len - 1);
`ifdef FFT_CNT_BITREV_EN
    x.rev   = x.busy ? rev_of(m_idx, m_len) : 0;
`else
    x.rev   = m_idx;
`endif
    return x;
  endfunction

  task automatic step(input bit s, input bit c,
                      input bit e, input int l,
                      input bit r);
    exp_t x;
    start = s; clr = c; ce = e;
    log2_len = SW'(l); nrst = r;
    model(s, c, e, l, r);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      note(1'b0, "sb_empty");
    end else begin
      x = exp_q.pop_front();
      note(int'(o_idx) == x.idx, "sb_idx");
      note(int'(o_stage) == x.stage, "sb_stage");
      note(int'(o_rev) == x.rev, "sb_rev");
      note(busy === x.busy, "sb_busy");
      note(o_done === x.done, "sb_done");
      note(o_last_idx === x.li, "sb_last_idx");
      note(o_last_stage === x.ls, "sb_last_stage");
    end
  endtask

  int n;
  int done_cnt;

  initial begin
    start = 0; clr = 0; ce = 0;
    log2_len = '0; nrst = 0;

    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 0);
    n_tests++;
    if (busy !== 1'b0 || o_done !== 1'b0 ||
        o_idx !== '0 || o_stage !== '0 ||
        o_rev !== '0 || o_last_idx !== 1'b0 ||
        o_last_stage !== 1'b0) begin
      n_fail++;
      $error("FAIL reset state busy=%0b done=%0b idx=%0d",
             busy, o_done, o_idx);
    end
    note(busy === 1'b0, "rst_busy");
    note(o_idx === '0, "rst_idx");
    note(o_rev === '0, "rst_rev");

    step(1, 0, 1, 3, 1);
    note(busy === 1'b1, "l3_start_busy");
    note(o_idx === '0, "l3_start_idx");
    done_cnt = 0;
    n = 0;
    while (n < 100 && !o_done) begin
      step(0, 0, 1, 3, 1);
      n++;
      if (o_done) done_cnt++;
      if (n == 10)
        note(int'(o_stage) == 1, "l3_stage_at10");
    end
    n_tests++;
    if (!o_done) begin
      n_fail++;
      $error("FAIL l3 wait expired after %0d steps", n);
    end
    note(n == 24, "l3_done_edges");
    note(busy === 1'b0, "l3_busy_at_done");
    step(0, 0, 1, 3, 1);
    note(done_cnt + int'(o_done) == 1, "l3_done_once");

    step(1, 0, 0, 2, 1);
    n = 0;
    while (n < 100 && !o_done) begin
      n++;
      step(0, 0, (n % 2) == 0, 2, 1);
    end
    n_tests++;
    if (!o_done) begin
      n_fail++;
      $error("FAIL l2 wait expired after %0d steps", n);
    end
    note(n == 16, "l2_toggle_clocks");
    step(0, 0, 0, 2, 1);

    step(1, 0, 0, 3, 1);
    for (int i = 0; i < 13; i++) step(0, 0, 1, 3, 1);
    note(int'(o_idx) == 5, "clr_pre_idx");
    note(int'(o_stage) == 1, "clr_pre_stage");
    step(1, 1, 1, 3, 1);
    note(busy === 1'b0, "clr_busy");
    note(o_done === 1'b0, "clr_done");
    note(o_idx === '0, "clr_idx");
    step(1, 0, 1, 3, 1);
    note(busy === 1'b1, "clr_restart_busy");
    note(o_idx === '0, "clr_restart_idx");
    note(o_stage === '0, "clr_restart_stage");
    step(0, 1, 0, 3, 1);

    step(1, 0, 1, 0, 1);
    note(busy === 1'b0, "len0_busy");
    step(0, 0, 1, 0, 1);

    step(1, 0, 0, 15, 1);
    for (int i = 0; i < 4094; i++) step(0, 0, 1, 15, 1);
    note(o_last_idx === 1'b0, "clamp_pre_last");
    step(0, 0, 1, 15, 1);
    note(int'(o_idx) == 4095, "clamp_idx");
    note(o_last_idx === 1'b1, "clamp_last_idx");
    step(0, 0, 1, 15, 1);
    note(int'(o_stage) == 1, "clamp_wrap_stage");
    step(0, 1, 0, 0, 1);

    step(1, 0, 1, 1, 1);
    step(1, 0, 1, 1, 1);
    note(int'(o_idx) == 1, "hold_run_idx");
    step(1, 0, 1, 1, 1);
    note(o_done === 1'b1, "hold_done");
    step(1, 0, 1, 1, 1);
    note(busy === 1'b0, "hold_idle_busy");
    step(1, 0, 1, 1, 1);
    note(busy === 1'b1, "hold_reaccept");
    step(0, 1, 0, 0, 1);

    step(1, 0, 0, 3, 1);
    for (int i = 1; i <= 7; i++) begin
      step(0, 0, 1, 3, 1);
`ifdef FFT_CNT_BITREV_EN
      if (i == 1) note(int'(o_rev) == 4, "rev_idx1");
      if (i == 6) note(int'(o_rev) == 3, "rev_idx6");
      if (i == 7) note(int'(o_rev) == 7, "rev_idx7");
`else
      note(int'(o_rev) == i, "rev_eq_idx");
`endif
    end
    step(0, 1, 0, 0, 1);

    step(1, 0, 0, 4, 1);
    for (int i = 0; i < 35; i++) step(0, 0, 1, 4, 1);
    note(int'(o_idx) == 3, "nrst_pre_idx");
    note(int'(o_stage) == 2, "nrst_pre_stage");
    step(0, 0, 1, 4, 0);
    note(busy === 1'b0, "nrst_busy");
    note(o_idx === '0, "nrst_idx");
    note(o_stage === '0, "nrst_stage");
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 4, 1);
      if (o_done) done_cnt++;
    end
    note(done_cnt == 0, "nrst_no_done");

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
